cmd_dispatch: RTL
=================

CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width.
REQ-002 SHALL have parameter DATA_W, default 64, register data width; command word width CMD_W = 1+ADDR_W+DATA_W (72 by default).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have fifo_rd_en  out  1  pop request to the command FIFO read side.
REQ-006 SHALL have fifo_rd_data  in  CMD_W  popped word, valid the cycle after fifo_rd_en; layout {we[CMD_W-1], addr[ADDR_W+DATA_W-1:DATA_W], data[DATA_W-1:0]}.
REQ-007 SHALL have fifo_rd_empty  in  1  FIFO empty flag.
REQ-008 SHALL have pause  in  1  hold off new fetches, e.g. a vsync wait.
REQ-009 SHALL have reg_valid  out  1  register access valid.
REQ-010 SHALL have reg_ready  in  1  register file accepts the access.
REQ-011 SHALL have reg_we  out  1  1=write, 0=read.
REQ-012 SHALL have reg_addr  out  ADDR_W  register address.
REQ-013 SHALL have reg_wdata  out  DATA_W  write data.
REQ-014 SHALL have busy  out  1  high when state != IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, FETCH, ISSUE.
REQ-016 IDLE: fifo_rd_en = !fifo_rd_empty && !pause (combinational); when it is 1, next state is FETCH.
REQ-017 FETCH: fifo_rd_en=0; capture fifo_rd_data into reg_we/reg_addr/reg_wdata; set reg_valid=1; next state ISSUE.
REQ-018 ISSUE, reg_ready=0: outputs SHALL stay stable; reg_valid held; no pop.
REQ-019 ISSUE, reg_ready=1 with !fifo_rd_empty && !pause: assert fifo_rd_en the same cycle; clear reg_valid; next state FETCH (back-to-back pop).
REQ-020 ISSUE, reg_ready=1 otherwise: clear reg_valid; next state IDLE.
REQ-021 Latency: reg_valid SHALL rise exactly 2 cycles after the fifo_rd_en cycle; sustained throughput is 1 command per 2 cycles.
REQ-022 SHALL never assert fifo_rd_en while fifo_rd_empty=1, and SHALL never have more than one popped command outstanding.
REQ-023 pause SHALL only block new pops; a command already in FETCH or ISSUE SHALL complete normally.
REQ-024 reg_wdata SHALL be passed through as captured when reg_we=0 (don't-care for the register file); no other decode.
REQ-025 A FIFO that is non-empty immediately after reset (boot-pre-populated) SHALL be popped in the first IDLE cycle following reset release.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, reg_valid=0, reg_we=0, reg_addr=0, reg_wdata=0, busy=0; fifo_rd_en=0 while rst_n is low.
REQ-027 Reset mid-transfer SHALL drop the in-flight command without re-popping it; no pop occurs in the first cycle after release unless the IDLE conditions hold.

Configuration
REQ-028 Macro CMD_DISPATCH_STATS_EN defined: SHALL add output cmd_count (16 bits), reset 0, incremented by 1 on each reg_valid&&reg_ready cycle and wrapping 0xFFFF->0x0000.
REQ-029 Macro CMD_DISPATCH_STATS_EN undefined: port cmd_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Single write: FIFO holds {1,7'h12,64'hDEAD_BEEF_0000_0001}, reg_ready=1 -> fifo_rd_en 1 cycle; 2 cycles later reg_valid=1, reg_we=1, reg_addr=0x12, data matches; then IDLE, busy=0.
REQ-031 Backpressure: reg_ready=0 for 5 cycles with 2 queued commands -> reg_valid and outputs stable for 5 cycles, no second pop until the ready cycle, then the second command follows 2 cycles later.
REQ-032 Burst of 4 commands, reg_ready=1 -> pops at cycles 0,2,4,6; reg_valid at cycles 2,4,6,8; in order; cmd_count=4 when the macro is defined.
REQ-033 pause=1 asserted during ISSUE with 3 queued -> the current command completes, no further fifo_rd_en until pause=0, then the next pop occurs in the same IDLE cycle that pause falls.
REQ-034 rst_n pulsed low during ISSUE -> reg_valid=0 immediately (asynchronous), state IDLE, cmd_count=0; the dropped command is not reissued.
REQ-035 Empty FIFO, reg_ready toggling for 20 cycles -> fifo_rd_en and reg_valid stay 0.

Source files
------------

// File: rtl/cmd_dispatch.sv
// Command dispatcher: pops {we, addr, data} words from a command FIFO and issues them as
// valid/ready register accesses. Optional CMD_DISPATCH_STATS_EN adds a 16-bit handshake counter.
module cmd_dispatch #(
  parameter  int ADDR_W = 7,
  parameter  int DATA_W = 64,
  localparam int CMD_W  = 1 + ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_rd_en,
  input  logic [CMD_W-1:0]  fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic              pause,
  output logic              reg_valid,
  input  logic              reg_ready,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              busy
`ifdef CMD_DISPATCH_STATS_EN
  ,
  output logic [15:0]       cmd_count
`endif
);

  // state | meaning
  // IDLE  | nothing outstanding; pops when FIFO non-empty and not paused
  // FETCH | popped word arrives on fifo_rd_data; captured into the access registers
  // ISSUE | reg_valid high until reg_ready; may pop the next word on the accepting cycle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pop_ok;
  logic              pop_c;

  assign pop_ok = !fifo_rd_empty && !pause;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop_ok) begin
          pop_c   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        we_d    = fifo_rd_data[CMD_W-1];
        addr_d  = fifo_rd_data[ADDR_W+DATA_W-1:DATA_W];
        wdata_d = fifo_rd_data[DATA_W-1:0];
        valid_d = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (reg_ready) begin
          valid_d = 1'b0;
          if (pop_ok) begin
            pop_c   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State is forced to IDLE during reset, so the pop must also be gated by rst_n itself.
  assign fifo_rd_en = pop_c && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign reg_valid = valid_q;
  assign reg_we    = we_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef CMD_DISPATCH_STATS_EN
  logic [15:0] cmd_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_count_q <= 16'd0;
    end else if (valid_q && reg_ready) begin
      cmd_count_q <= cmd_count_q + 16'd1;
    end
  end

  assign cmd_count = cmd_count_q;
`endif

endmodule
